// File: rtl/mm_job_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_job_sched_pkg
// Description : Shared types and constants for the matmul job scheduler:
//               engine precision-mode encodings (2'd3 reserved), the number
//               of tile_done pulses that make up one matrix, tile counter
//               width, and the scheduler FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_job_sched_pkg;

    typedef enum logic [1:0] {
        MODE_INT8 = 2'd0,
        MODE_FP16 = 2'd1,
        MODE_BF16 = 2'd2,
        MODE_RSVD = 2'd3
    } mm_mode_e;

    // 32x32 tiles per matrix
    localparam int TILES_PER_MTRX = 1024;

    // Counter is wide enough to show overruns up to 2047 before saturating
    localparam int                    TILE_CNT_W   = 11;
    localparam logic [TILE_CNT_W-1:0] TILE_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_CPL    = 2'd3
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/mm_job_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mm_job_sched_if
// Description : Bundle of the scheduler's job port, engine port, completion
//               port and status outputs. Signal names carry the direction
//               as seen from the scheduler.
//               slave  : scheduler view (mm_job_sched)
//               master : job source / engine / completion sink view
// Revision    : 1.0 - initial release
// ============================================================================
interface mm_job_sched_if #(
    parameter int ID_W      = 4,
    parameter int JOB_DEPTH = 4
);
    localparam int QLVL_W = $clog2(JOB_DEPTH) + 1;

    // job port
    logic              i_job_valid;
    logic              o_job_ready;
    logic [1:0]        i_job_mode;
    logic [ID_W-1:0]   i_job_id;
    // engine port
    logic              o_mm_start;
    logic [1:0]        o_mm_mode;
    logic              i_tile_done;
    logic              i_mtrx_done;
    // completion port
    logic              o_cpl_valid;
    logic              i_cpl_ready;
    logic [ID_W-1:0]   o_cpl_id;
    logic [10:0]       o_cpl_tiles;
    logic              o_cpl_err;
    // status
    logic              o_busy;
    logic [QLVL_W-1:0] o_qlevel;

    modport slave (
        input  i_job_valid, i_job_mode, i_job_id,
        input  i_tile_done, i_mtrx_done, i_cpl_ready,
        output o_job_ready, o_mm_start, o_mm_mode,
        output o_cpl_valid, o_cpl_id, o_cpl_tiles, o_cpl_err,
        output o_busy, o_qlevel
    );

    modport master (
        output i_job_valid, i_job_mode, i_job_id,
        output i_tile_done, i_mtrx_done, i_cpl_ready,
        input  o_job_ready, o_mm_start, o_mm_mode,
        input  o_cpl_valid, o_cpl_id, o_cpl_tiles, o_cpl_err,
        input  o_busy, o_qlevel
    );

endinterface
`default_nettype wire

// File: rtl/mm_job_sched_job_fifo.sv
`default_nettype none
// ============================================================================
// Module      : job_fifo
// Description : Synchronous FIFO with occupancy count and full/empty flags.
//               Head entry is presented on o_dout whenever non-empty.
//               Push is ignored when full and pop when empty; a push is
//               never allowed through a full FIFO even with a same-cycle pop.
// Ports       : i_clk, i_rst_n (async, active-low)
//               i_push/i_din, i_pop/o_dout, o_count, o_full, o_empty
// Revision    : 1.0 - initial release
// ============================================================================
module job_fifo #(
    parameter  int WIDTH = 6,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_dout,
    output logic      [CW-1:0]    o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage needs no reset: contents are only observed while non-empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_job_sched.sv
`default_nettype none
// ============================================================================
// Module      : mm_job_sched
// Description : Job scheduler in front of the matrix-multiply engine. Queues
//               jobs (mode + tag), launches one at a time with a single
//               cycle start pulse, counts tile_done pulses until
//               matrix_done, and returns one completion record per job.
//               Reserved-mode jobs complete with an error, never started.
// Ports       : i_clk, i_rst_n (async, active-low)
//               bus (mm_job_sched_if.slave): job, engine, completion and
//               status signals.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_job_sched
    import mm_job_sched_pkg::*;
#(
    parameter int JOB_DEPTH = 4,
    parameter int ID_W      = 4,
    parameter int TILES     = mm_job_sched_pkg::TILES_PER_MTRX
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst_n,
    mm_job_sched_if.slave  bus
);

    localparam int QLVL_W = $clog2(JOB_DEPTH) + 1;

    sched_state_e          r_state;
    sched_state_e          w_state_next;
    logic                  w_pop;
    logic [ID_W+1:0]       w_head;
    logic [1:0]            w_head_mode;
    logic [ID_W-1:0]       w_head_id;
    logic                  w_full;
    logic                  w_empty;
    logic [QLVL_W-1:0]     w_count;
    logic [ID_W-1:0]       r_id;
    logic [1:0]            r_mm_mode;
    logic [TILE_CNT_W-1:0] r_tiles;
    logic [TILE_CNT_W-1:0] w_tiles_inc;
    logic                  r_err;

    job_fifo #(
        .WIDTH (ID_W + 2),
        .DEPTH (JOB_DEPTH)
    ) u_job_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (bus.i_job_valid),
        .i_din   ({bus.i_job_mode, bus.i_job_id}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_mode = w_head[ID_W +: 2];
    assign w_head_id   = w_head[ID_W-1:0];

    // Saturating count including any tile_done in the current cycle, so a
    // tile_done coincident with mtrx_done is part of the final count.
    assign w_tiles_inc = (bus.i_tile_done && (r_tiles != TILE_CNT_MAX))
                       ? r_tiles + 1'b1 : r_tiles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = (w_head_mode == MODE_RSVD) ? ST_CPL : ST_LAUNCH;
                end
            end
            ST_LAUNCH: w_state_next = ST_RUN;
            ST_RUN: begin
                if (bus.i_mtrx_done) w_state_next = ST_CPL;
            end
            ST_CPL: begin
                if (bus.i_cpl_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Job context and tile counter. The engine mode register only loads for
    // jobs that will actually run, so it holds its last value otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id      <= '0;
            r_mm_mode <= '0;
            r_tiles   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_id <= w_head_id;
                if (w_head_mode == MODE_RSVD) begin
                    r_tiles <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_mm_mode <= w_head_mode;
                end
            end
            if (r_state == ST_LAUNCH) begin
                r_tiles <= '0;
                r_err   <= 1'b0;
            end
            if (r_state == ST_RUN) begin
                r_tiles <= w_tiles_inc;
                if (bus.i_mtrx_done) begin
                    r_err <= (w_tiles_inc != TILE_CNT_W'(TILES));
                end
            end
        end
    end

    assign bus.o_job_ready = !w_full;
    assign bus.o_mm_start  = (r_state == ST_LAUNCH);
    assign bus.o_mm_mode   = r_mm_mode;
    assign bus.o_cpl_valid = (r_state == ST_CPL);
    assign bus.o_cpl_id    = r_id;
    assign bus.o_cpl_tiles = r_tiles;
    assign bus.o_cpl_err   = r_err;
    assign bus.o_busy      = (r_state != ST_IDLE) || !w_empty;
    assign bus.o_qlevel    = w_count;

endmodule
`default_nettype wire
